serial_subtractor: RTL and testbench
====================================

// Module: serial_subtractor
// PURPOSE
//   Bit-serial N-bit subtractor: diff = a - b - bin, LSB first, one bit per clock.
//   Uses one full-subtractor cell plus a registered borrow.
//   Paired with the registered full adder in the arithmetic lab datapath.
//   Operands arrive and results leave over valid/ready handshakes.
// PARAMETERS
//   WIDTH  8  operand/result width in bits; legal values are WIDTH >= 2
// PORTS
//   clk        in   1      single clock, rising edge
//   rst_n      in   1      reset, asynchronous, active-low
//   in_valid   in   1      operand set valid
//   in_ready   out  1      block can accept operands
//   a_in       in   WIDTH  minuend
//   b_in       in   WIDTH  subtrahend
//   bin_in     in   1      borrow in
//   out_valid  out  1      result valid
//   out_ready  in   1      consumer accepts result
//   diff_out   out  WIDTH  a - b - bin, modulo 2^WIDTH
//   bout_out   out  1      borrow out (1 when unsigned a < b + bin)
//   ovf_out    out  1      signed overflow; present only with SERSUB_OVF_EN
// BEHAVIOUR
//   Clock and reset:
//     - One clock, clk. Reset rst_n is asynchronous, active-low.
//     - Reset: state=IDLE, in_ready=1, out_valid=0, diff_out=0, bout_out=0,
//       ovf_out=0, shift regs/borrow/count cleared.
//   State machine (enum in package): IDLE -> SHIFT -> DONE -> IDLE.
//   - IDLE: in_ready=1.
//     - On in_valid&&in_ready: latch a,b into shift regs, borrow<=bin_in,
//       count<=0, go to SHIFT.
//     - in_valid while not ready is ignored (no capture).
//   - SHIFT: in_ready=0. Each cycle the cell takes a_sr[0], b_sr[0] and borrow:
//     - d  = a^b^br
//     - br' = (~a&b) | (~(a^b)&br)
//     - d shifts into the result reg at the MSB; a_sr/b_sr shift right;
//       count++.
//     - When count==WIDTH-1 the step completes: go to DONE, load diff_out and
//       bout_out=br', set out_valid=1.
//   - Latency: out_valid rises on the WIDTH-th rising edge after the accepting
//     edge (8 cycles for WIDTH=8).
//   - DONE: out_valid=1, in_ready=0.
//     - diff_out/bout_out/ovf_out held stable until out_valid&&out_ready.
//     - On that edge: out_valid<=0, go to IDLE.
//     - Throughput: one result per WIDTH+2 cycles minimum; no overlap of jobs.
//   - Outputs are registered; in_ready is decoded from the state register only.
//   - Reset mid-operation: abort immediately; no partial result is ever presented.
//   - out_ready in IDLE/SHIFT is ignored.
//   - Width rules:
//     - count is $clog2(WIDTH) bits.
//     - Arithmetic is modulo 2^WIDTH; borrow is the only carry-out.
// CONFIGURATION
//   SERSUB_OVF_EN defined:
//     - ovf_out port exists.
//     - At the DONE transition: ovf = (a_msb ^ b_msb) & (a_msb ^ d_msb),
//       using the MSB bits consumed in the final SHIFT cycle.
//     - Held with diff_out; cleared on reset.
//   SERSUB_OVF_EN undefined:
//     - No ovf_out port; no overflow logic.
//     - All other timing is identical.
// STRUCTURE
//   Package serial_sub_pkg:
//     - typedef enum logic [1:0] {IDLE, SHIFT, DONE} sersub_state_t
//     - default WIDTH localparam
//   Sub-module full_subtractor_cell:
//     - Combinational: a, b, bin -> d, bout.
//     - Instantiated once; all state lives in serial_subtractor.
// TESTING (WIDTH=8, out_ready=1 unless stated)
//   1 a=0x05 b=0x03 bin=0 -> diff=0x02 bout=0, out_valid 8 cycles after accept.
//   2 a=0x03 b=0x05 bin=0 -> diff=0xFE bout=1; a=0x00 b=0x00 bin=1 -> diff=0xFF bout=1.
//   3 out_ready held 0 for 5 cycles in DONE -> diff/bout stable, in_ready=0;
//     new in_valid not captured.
//   4 rst_n pulsed low at SHIFT count=4 -> immediately in_ready=1, out_valid=0,
//     diff_out=0; next op a=0xFF b=0x01 -> 0xFE bout=0.
//   5 back-to-back in_valid held high with 2 operand sets -> results in order,
//     accepts exactly WIDTH+2 cycles apart.
//   6 SERSUB_OVF_EN: a=0x80 b=0x01 -> diff=0x7F ovf=1; a=0x10 b=0x01 -> 0x0F ovf=0.

Source files
------------

// File: rtl/serial_sub_pkg.sv
// serial_sub_pkg: shared state encoding and default width for the bit-serial subtractor
package serial_sub_pkg;

    localparam int SERSUB_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } sersub_state_t;

endpackage

// File: rtl/full_subtractor_cell.sv
// full_subtractor_cell: one-bit combinational full subtractor, d = a - b - bin
module full_subtractor_cell (
    input  logic a_i,
    input  logic b_i,
    input  logic bin_i,
    output logic d_o,
    output logic bout_o
);

    // Borrow out when a is 0 and b is 1, or when a equals b and a borrow came in.
    always_comb begin
        d_o    = a_i ^ b_i ^ bin_i;
        bout_o = (~a_i & b_i) | (~(a_i ^ b_i) & bin_i);
    end

endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: LSB-first bit-serial a - b - bin with valid/ready handshakes; ovf_out exists when SERSUB_OVF_EN is defined
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = SERSUB_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             bin_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff_out,
    output logic             bout_out
`ifdef SERSUB_OVF_EN
    ,
    output logic             ovf_out
`endif
);

    localparam int CW = $clog2(WIDTH);

    sersub_state_t    state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic [WIDTH-2:0] res_q, res_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             br_q, br_d;
    logic             bout_q, bout_d;
    logic             out_valid_q, out_valid_d;
    logic             cell_d, cell_bout;
    logic             last;
`ifdef SERSUB_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    full_subtractor_cell u_cell (
        .a_i    (a_sr_q[0]),
        .b_i    (b_sr_q[0]),
        .bin_i  (br_q),
        .d_o    (cell_d),
        .bout_o (cell_bout)
    );

    assign last      = cnt_q == CW'(WIDTH - 1);
    assign in_ready  = state_q == IDLE;
    assign out_valid = out_valid_q;
    assign diff_out  = diff_q;
    assign bout_out  = bout_q;
`ifdef SERSUB_OVF_EN
    assign ovf_out   = ovf_q;
`endif

    // Next-state: capture in IDLE, one cell step per SHIFT cycle, hold results in DONE.
    always_comb begin
        state_d     = state_q;
        a_sr_d      = a_sr_q;
        b_sr_d      = b_sr_q;
        diff_d      = diff_q;
        res_d       = res_q;
        cnt_d       = cnt_q;
        br_d        = br_q;
        bout_d      = bout_q;
        out_valid_d = out_valid_q;
`ifdef SERSUB_OVF_EN
        ovf_d       = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_sr_d  = a_in;
                    b_sr_d  = b_in;
                    br_d    = bin_in;
                    cnt_d   = '0;
                    res_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                a_sr_d = a_sr_q >> 1;
                b_sr_d = b_sr_q >> 1;
                br_d   = cell_bout;
                cnt_d  = cnt_q + 1'b1;
                res_d  = (WIDTH-1)'({cell_d, res_q} >> 1);
                if (last) begin
                    state_d     = DONE;
                    diff_d      = {cell_d, res_q};
                    bout_d      = cell_bout;
                    out_valid_d = 1'b1;
`ifdef SERSUB_OVF_EN
                    ovf_d       = (a_sr_q[0] ^ b_sr_q[0]) & (a_sr_q[0] ^ cell_d);
`endif
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register; an asynchronous reset aborts any job so no partial result is shown.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_sr_q      <= '0;
            b_sr_q      <= '0;
            diff_q      <= '0;
            res_q       <= '0;
            cnt_q       <= '0;
            br_q        <= 1'b0;
            bout_q      <= 1'b0;
            out_valid_q <= 1'b0;
`ifdef SERSUB_OVF_EN
            ovf_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            a_sr_q      <= a_sr_d;
            b_sr_q      <= b_sr_d;
            diff_q      <= diff_d;
            res_q       <= res_d;
            cnt_q       <= cnt_d;
            br_q        <= br_d;
            bout_q      <= bout_d;
            out_valid_q <= out_valid_d;
`ifdef SERSUB_OVF_EN
            ovf_q       <= ovf_d;
`endif
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: table, corner-case and random checks of serial_subtractor against an arithmetic model (honours SERSUB_OVF_EN)
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a_in = '0;
    logic [W-1:0] b_in = '0;
    logic         bin_in = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] diff_out;
    logic         bout_out;
`ifdef SERSUB_OVF_EN
    logic         ovf_out;
`endif

    int n_cmp = 0;
    int n_err = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_in      (a_in),
        .b_in      (b_in),
        .bin_in    (bin_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff_out  (diff_out),
        .bout_out  (bout_out)
`ifdef SERSUB_OVF_EN
        ,
        .ovf_out   (ovf_out)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1);
    end

    int           cyc = 0;
    int           acc_t[$];
    logic [W-1:0] got_q[$];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (in_valid && in_ready) acc_t.push_back(cyc);
        if (out_valid && out_ready) got_q.push_back(diff_out);
    end

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         bin;
        logic [W-1:0] diff;
        logic         bout;
        logic         ovf;
    } vec_t;

    vec_t tbl[8];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", name, got, exp);
        end
    endtask

    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                                  output logic [W-1:0] d, output logic bo, output logic ov);
        int r, s;
        r  = int'(a) - int'(b) - int'(bin);
        d  = r[W-1:0];
        bo = r < 0;
        s  = int'($signed(a)) - int'($signed(b)) - int'(bin);
        ov = (s < -(1 << (W - 1))) || (s > (1 << (W - 1)) - 1);
    endfunction

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin, output int lat);
        int k;
        a_in = a;
        b_in = b;
        bin_in = bin;
        in_valid = 1'b1;
        k = 0;
        while (!in_ready && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic check_out(input string name, input logic [W-1:0] d, input logic bo, input logic ov);
        check({name, "_diff"}, 32'(diff_out), 32'(d));
        check({name, "_bout"}, 32'(bout_out), 32'(bo));
`ifdef SERSUB_OVF_EN
        check({name, "_ovf"}, 32'(ovf_out), 32'(ov));
`endif
    endtask

    initial begin
        int           lat, k;
        logic [W-1:0] ea, eb, ed;
        logic         ebin, ebo, eov;
        logic [W-1:0] held;

        tbl[0] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0};
        tbl[1] = '{8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0};
        tbl[2] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0};
        tbl[3] = '{8'hFF, 8'h01, 1'b0, 8'hFE, 1'b0, 1'b0};
        tbl[4] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
        tbl[5] = '{8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 1'b0};
        tbl[6] = '{8'h00, 8'hFF, 1'b1, 8'h00, 1'b1, 1'b0};
        tbl[7] = '{8'h7F, 8'h80, 1'b0, 8'hFF, 1'b1, 1'b1};

        #12;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check_out("rst", '0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) begin
            run_op(tbl[i].a, tbl[i].b, tbl[i].bin, lat);
            check($sformatf("tbl%0d_latency", i), 32'(lat), 32'(W));
            check_out($sformatf("tbl%0d", i), tbl[i].diff, tbl[i].bout, tbl[i].ovf);
        end
        @(posedge clk); #1;

        out_ready = 1'b0;
        run_op(8'h5A, 8'h33, 1'b0, lat);
        check("stall_latency", 32'(lat), 32'(W));
        held = diff_out;
        check("stall_first", 32'(held), 32'h27);
        a_in = 8'hAA;
        b_in = 8'h11;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check($sformatf("stall%0d_diff", i), 32'(diff_out), 32'h27);
            check($sformatf("stall%0d_bout", i), 32'(bout_out), 32'd0);
            check($sformatf("stall%0d_in_ready", i), 32'(in_ready), 32'd0);
            check($sformatf("stall%0d_out_valid", i), 32'(out_valid), 32'd1);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("stall_release_valid", 32'(out_valid), 32'd0);
        check("stall_release_ready", 32'(in_ready), 32'd1);

        a_in = 8'h3C;
        b_in = 8'h0F;
        bin_in = 1'b0;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_diff", 32'(diff_out), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_op(8'hFF, 8'h01, 1'b0, lat);
        check("postrst_latency", 32'(lat), 32'(W));
        check_out("postrst", 8'hFE, 1'b0, 1'b0);
        @(posedge clk); #1;

        acc_t.delete();
        got_q.delete();
        a_in = 8'h21;
        b_in = 8'h42;
        bin_in = 1'b1;
        in_valid = 1'b1;
        k = 0;
        while (acc_t.size() < 1 && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        a_in = 8'hC8;
        b_in = 8'h64;
        bin_in = 1'b0;
        k = 0;
        while (acc_t.size() < 2 && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        in_valid = 1'b0;
        k = 0;
        while (got_q.size() < 2 && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        check("b2b_accepts", 32'(acc_t.size()), 32'd2);
        check("b2b_results", 32'(got_q.size()), 32'd2);
        if (acc_t.size() == 2) check("b2b_gap", 32'(acc_t[1] - acc_t[0]), 32'(W + 2));
        model(8'h21, 8'h42, 1'b1, ed, ebo, eov);
        if (got_q.size() >= 1) check("b2b_res0", 32'(got_q[0]), 32'(ed));
        model(8'hC8, 8'h64, 1'b0, ed, ebo, eov);
        if (got_q.size() >= 2) check("b2b_res1", 32'(got_q[1]), 32'(ed));
        @(posedge clk); #1;

        for (int i = 0; i < 40; i++) begin
            ea = W'($urandom);
            eb = W'($urandom);
            ebin = 1'($urandom);
            model(ea, eb, ebin, ed, ebo, eov);
            run_op(ea, eb, ebin, lat);
            check($sformatf("rnd%0d_latency", i), 32'(lat), 32'(W));
            check_out($sformatf("rnd%0d", i), ed, ebo, eov);
        end
        @(posedge clk); #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
